// File: rtl/dec_trace_capture_if.sv
// Readout handshake bundle for the decimated trace FIFO.
// master: drives rd_valid/rd_time/rd_data; slave: drives rd_ready.
interface dec_trace_capture_if #(
    parameter int TIME_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [TIME_WIDTH-1:0] rd_time;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_time,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_time,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/dec_trace_capture.sv
// Decimated trace capture: {emu_time, probe_in} per strobe into an FWFT FIFO.
// Ports: emu_clk/emu_rst, strobe/time/probe in, arm/trig/num_samples control,
// rd (readout handshake), level/busy/done/overflow status.
module dec_trace_capture #(
    parameter int TIME_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  emu_dec_cmp,
    input  logic [TIME_WIDTH-1:0] emu_time,
    input  logic [DATA_WIDTH-1:0] probe_in,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    dec_trace_capture_if.master   rd,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RW    = TIME_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [RW-1:0]        mem [DEPTH];
    ptr_t                 wr_ptr, rd_ptr;
    ptr_t                 wr_ptr_nxt, rd_ptr_nxt;
    logic [1:0]           state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, target;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 active, cap, last;
    logic                 full, pop, push, drop;
    logic                 valid_q;
    logic [RW-1:0]        head_q, head_nxt, rec;

    assign rec  = {emu_time, probe_in};
    assign full = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                  (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign pop  = valid_q && rd.rd_ready;

    // A trigger seen while armed opens the window in the same cycle.
    assign active  = (state == S_CAPTURE) || ((state == S_ARMED) && trig);
    assign cap     = active && emu_dec_cmp && (cnt < target);
    assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign last    = cap && (cnt_inc == {1'b0, target});

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign rd_ptr_nxt = pop  ? rd_ptr + ptr_t'(1) : rd_ptr;
    assign wr_ptr_nxt = push ? wr_ptr + ptr_t'(1) : wr_ptr;

    // Next head bypasses memory when the record lands in the head slot.
    assign head_nxt =
        (push && (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0]))
        ? rec : mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];

    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = (num_samples == '0) ? S_DONE : S_ARMED;
        end else if (last) begin
            state_nxt = S_DONE;
        end else if ((state == S_ARMED) && trig) begin
            state_nxt = S_CAPTURE;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (push && !arm) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rec;
        end
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            target   <= '0;
            overflow <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                target   <= num_samples;
                overflow <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr_nxt;
                rd_ptr  <= rd_ptr_nxt;
                valid_q <= (wr_ptr_nxt != rd_ptr_nxt);
                if (cap) begin
                    cnt <= cnt_inc[CNT_WIDTH-1:0];
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (wr_ptr_nxt != rd_ptr_nxt) begin
                    head_q <= head_nxt;
                end
            end
        end
    end

    assign level       = wr_ptr - rd_ptr;
    assign busy        = (state == S_ARMED) || (state == S_CAPTURE);
    assign done        = (state == S_DONE);
    assign rd.rd_valid = valid_q;
    assign rd.rd_time  = head_q[RW-1 -: TIME_WIDTH];
    assign rd.rd_data  = head_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dec_trace_capture.sv
// Scoreboard bench for dec_trace_capture: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_dec_trace_capture;

    logic        emu_clk = 1'b0;
    logic        emu_rst = 1'b1;
    logic        emu_dec_cmp = 1'b0;
    logic [31:0] emu_time = '0;
    logic [15:0] probe_in = '0;
    logic        arm = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] num_samples = '0;
    logic [4:0]  level;
    logic        busy, done, overflow;

    dec_trace_capture_if #(.TIME_WIDTH(32), .DATA_WIDTH(16)) rd_if ();

    dec_trace_capture #(
        .TIME_WIDTH(32), .DATA_WIDTH(16), .DEPTH_LOG2(4), .CNT_WIDTH(16)
    ) dut (
        .emu_clk(emu_clk),
        .emu_rst(emu_rst),
        .emu_dec_cmp(emu_dec_cmp),
        .emu_time(emu_time),
        .probe_in(probe_in),
        .arm(arm),
        .trig(trig),
        .num_samples(num_samples),
        .rd(rd_if),
        .level(level),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 emu_clk = ~emu_clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: queue of records the FIFO should hold, plus run state
    // (0 idle, 1 armed, 2 capturing, 3 done).
    logic [47:0] exp_q[$];
    int          m_st  = 0;
    int          m_cnt = 0;
    int          m_tgt = 0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Monitor: a handshake is committed at the coming edge unless arm flushes.
    always @(negedge emu_clk) begin
        if (!emu_rst && !arm && rd_if.rd_valid && rd_if.rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {63'd0, rd_if.rd_valid}, 64'd0);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("record", {16'd0, rd_if.rd_time, rd_if.rd_data},
                    {16'd0, e});
            end
        end
    end

    task automatic step(input logic a, input logic t, input logic s,
                        input logic r, input int n);
        logic [15:0] p;
        int          sz;
        @(posedge emu_clk);
        #1;
        cyc++;
        sz = exp_q.size();
        chk("level", {59'd0, level}, sz);
        chk("rd_valid", {63'd0, rd_if.rd_valid}, {63'd0, sz != 0});
        chk("busy", {63'd0, busy}, {63'd0, m_st == 1 || m_st == 2});
        chk("done", {63'd0, done}, {63'd0, m_st == 3});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        p = 16'($urandom);
        arm = a;
        trig = t;
        emu_dec_cmp = s;
        rd_if.rd_ready = r;
        num_samples = 16'(n);
        emu_time = cyc;
        probe_in = p;
        if (a) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_tgt = n;
            m_st = (n == 0) ? 3 : 1;
        end else if (((m_st == 2) || (m_st == 1 && t)) && s && m_cnt < m_tgt) begin
            m_cnt++;
            if (sz < 16 || (r && sz != 0)) exp_q.push_back({emu_time, p});
            else m_ovf = 1'b1;
            m_st = (m_cnt == m_tgt) ? 3 : 2;
        end else if (m_st == 1 && t) begin
            m_st = 2;
        end
    endtask

    task automatic async_reset();
        @(posedge emu_clk);
        #1;
        cyc++;
        arm = 0; trig = 0; emu_dec_cmp = 0; rd_if.rd_ready = 0;
        #2 emu_rst = 1'b1;
        #1;
        chk("rst_level", {59'd0, level}, 64'd0);
        chk("rst_valid", {63'd0, rd_if.rd_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_time", {32'd0, rd_if.rd_time}, 64'd0);
        chk("rst_data", {48'd0, rd_if.rd_data}, 64'd0);
        exp_q.delete();
        m_st = 0; m_cnt = 0; m_tgt = 0; m_ovf = 1'b0;
        #3 emu_rst = 1'b0;
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        #2;
        chk("init_level", {59'd0, level}, 64'd0);
        chk("init_valid", {63'd0, rd_if.rd_valid}, 64'd0);
        chk("init_done", {63'd0, done}, 64'd0);
        chk("init_time", {32'd0, rd_if.rd_time}, 64'd0);
        chk("init_data", {48'd0, rd_if.rd_data}, 64'd0);
        #6 emu_rst = 1'b0;

        // Strobe every 4th cycle, 5 samples, trigger two cycles after arm.
        step(1, 0, 0, 0, 5);
        for (int i = 0; i < 30; i++) step(0, i >= 1, (i % 4) == 3, 0, 5);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 5);

        // Trigger and strobe coincide while armed.
        step(1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 3);
        step(0, 1, 1, 0, 3);
        for (int i = 0; i < 8; i++) step(0, 0, i % 2, 1, 3);

        // Overfill: 20 samples into 16 slots, then drain.
        step(1, 0, 0, 0, 20);
        for (int i = 0; i < 45; i++) step(0, 1, i % 2, 0, 20);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 20);

        // Full FIFO with a capture and a pop in the same cycle.
        step(1, 0, 0, 0, 18);
        for (int i = 0; i < 32; i++) step(0, 1, i % 2, 0, 18);
        step(0, 1, 1, 1, 18);
        step(0, 1, 0, 0, 18);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 18);

        // Re-arm mid-capture with 3 records stored and overflow set.
        step(1, 0, 0, 0, 25);
        for (int i = 0; i < 19; i++) step(0, 1, 1, 0, 25);
        for (int i = 0; i < 13; i++) step(0, 1, 0, 1, 25);
        step(1, 1, 1, 1, 10);
        step(0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 10);

        // Asynchronous reset mid-run, then a zero-length run.
        step(1, 0, 0, 0, 8);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8);
        async_reset();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 60) == 0, ($urandom % 6) == 0,
                 ($urandom % 3) == 0, ($urandom % 2) == 0,
                 int'($urandom % 24));
        end
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
